// File: rtl/matmul_sched_pkg.sv
// Shared types for the time-multiplexed matrix-multiply sequencer.
package matmul_sched_pkg;

   localparam int DW = 32;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      GAP,
      FIN
   } state_t;

endpackage

// File: rtl/matmul_sched_if.sv
// Operand/result bus between the sequencer and the single vecmul dot-product unit.
interface matmul_sched_if
   import matmul_sched_pkg::*;
#(
   parameter int MIDDLE = 3
) ();

   logic                         vm_en;
   logic [MIDDLE-1:0][DW-1:0]    vm_in1;
   logic [MIDDLE-1:0][DW-1:0]    vm_in2;
   logic [DW-1:0]                vm_result;
   logic                         vm_done;

   modport master (
      output vm_en,
      output vm_in1,
      output vm_in2,
      input  vm_result,
      input  vm_done
   );

   modport slave (
      input  vm_en,
      input  vm_in1,
      input  vm_in2,
      output vm_result,
      output vm_done
   );

endinterface

// File: rtl/matmul_sched.sv
// Computes C = A x B one dot product at a time through a shared vecmul unit,
// row-major over C, with a per-product hang timeout.
//
//   state | meaning
//   IDLE  | waiting for start; result and err hold their last values
//   RUN   | vecmul enabled on row i of A / column j of B, waiting for vm_done
//   GAP   | one cycle with vecmul disabled so it restarts; advance (i,j)
//   FIN   | one-cycle done pulse, then back to IDLE
module matmul_sched
   import matmul_sched_pkg::*;
#(
   parameter int LEFT    = 2,
   parameter int MIDDLE  = 3,
   parameter int RIGHT   = 4,
   parameter int TIMEOUT = 64
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  start,
   input  logic [LEFT-1:0][MIDDLE-1:0][DW-1:0]   in1,
   input  logic [MIDDLE-1:0][RIGHT-1:0][DW-1:0]  in2,
   output logic                                  busy,
   output logic                                  done,
   output logic                                  err,
   output logic [LEFT-1:0][RIGHT-1:0][DW-1:0]    result,
   matmul_sched_if.master                        vm
);

   localparam int IW = $clog2((LEFT  > 2) ? LEFT  : 2);
   localparam int JW = $clog2((RIGHT > 2) ? RIGHT : 2);
   localparam int TW = $clog2(TIMEOUT);

   localparam logic [IW-1:0] I_LAST = IW'(LEFT - 1);
   localparam logic [JW-1:0] J_LAST = JW'(RIGHT - 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

   state_t                                state_q;
   logic [IW-1:0]                         i_q;
   logic [JW-1:0]                         j_q;
   logic [TW-1:0]                         timer_q;
   logic                                  vm_en_q;
   logic [LEFT-1:0][MIDDLE-1:0][DW-1:0]   a_q;
   logic [MIDDLE-1:0][RIGHT-1:0][DW-1:0]  b_q;

   // Operands come straight from the latched copies, so they stay stable for the whole RUN.
   always_comb begin
      vm.vm_in1 = a_q[i_q];
      vm.vm_in2 = '0;
      for (int k = 0; k < MIDDLE; k++) begin
         vm.vm_in2[k] = b_q[k][j_q];
      end
   end

   assign vm.vm_en = vm_en_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         i_q     <= '0;
         j_q     <= '0;
         timer_q <= '0;
         vm_en_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         result  <= '0;
      end else begin
         done <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  a_q     <= in1;
                  b_q     <= in2;
                  result  <= '0;
                  err     <= 1'b0;
                  i_q     <= '0;
                  j_q     <= '0;
                  timer_q <= '0;
                  busy    <= 1'b1;
                  vm_en_q <= 1'b1;
                  state_q <= RUN;
               end
            end
            RUN: begin
               timer_q <= timer_q + 1'b1;
               // A completion on the terminal cycle still counts as a good product.
               if (vm.vm_done) begin
                  result[i_q][j_q] <= vm.vm_result;
                  vm_en_q          <= 1'b0;
                  state_q          <= GAP;
               end else if (timer_q == T_LAST) begin
                  err     <= 1'b1;
                  vm_en_q <= 1'b0;
                  done    <= 1'b1;
                  state_q <= FIN;
               end
            end
            GAP: begin
               if (j_q == J_LAST) begin
                  j_q <= '0;
                  i_q <= (i_q == I_LAST) ? '0 : i_q + 1'b1;
               end else begin
                  j_q <= j_q + 1'b1;
               end
               if (i_q == I_LAST && j_q == J_LAST) begin
                  done    <= 1'b1;
                  state_q <= FIN;
               end else begin
                  timer_q <= '0;
                  vm_en_q <= 1'b1;
                  state_q <= RUN;
               end
            end
            FIN: begin
               busy    <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_sched.sv
// Randomized scoreboard bench for matmul_sched with a behavioural vecmul of programmable latency.
module tb_matmul_sched;
   import matmul_sched_pkg::*;

   localparam int LEFT    = 2;
   localparam int MIDDLE  = 3;
   localparam int RIGHT   = 4;
   localparam int TIMEOUT = 64;
   localparam int N       = LEFT * RIGHT;

   typedef logic [LEFT-1:0][RIGHT-1:0][31:0] mat_c_t;

   typedef struct {
      mat_c_t c;
      int     err;
      int     done_cyc;
      int     busy_len;
      int     rises;
   } exp_t;

   logic                                  clk;
   logic                                  rst_n;
   logic                                  start;
   logic [LEFT-1:0][MIDDLE-1:0][31:0]     in1;
   logic [MIDDLE-1:0][RIGHT-1:0][31:0]    in2;
   logic                                  busy;
   logic                                  done;
   logic                                  err;
   mat_c_t                                result;

   matmul_sched_if #(.MIDDLE(MIDDLE)) vm_bus ();

   matmul_sched #(
      .LEFT(LEFT), .MIDDLE(MIDDLE), .RIGHT(RIGHT), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2),
      .busy(busy), .done(done), .err(err), .result(result), .vm(vm_bus)
   );

   int checks = 0;
   int fails  = 0;
   int cyc    = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural vecmul: vm_done on the lat-th enabled cycle, restarts whenever vm_en drops
   int          lat  = 1;
   bit          hung = 1'b0;
   int          run_cnt;
   logic [31:0] dot_v;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)               run_cnt <= 0;
      else if (!vm_bus.vm_en)   run_cnt <= 0;
      else                      run_cnt <= run_cnt + 1;
   end

   always_comb begin
      dot_v = '0;
      for (int k = 0; k < MIDDLE; k++) dot_v = dot_v + vm_bus.vm_in1[k] * vm_bus.vm_in2[k];
      vm_bus.vm_result = dot_v;
      vm_bus.vm_done   = vm_bus.vm_en && !hung && (run_cnt == lat - 1);
   end

   logic [31:0] A [LEFT][MIDDLE];
   logic [31:0] B [MIDDLE][RIGHT];
   exp_t        sb [$];

   task automatic chk_i(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chk_m(input string name, input mat_c_t act, input mat_c_t exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // reference: plain matrix product, or a timeout on the very first product
   function automatic exp_t model(input int c0, input int l, input bit hang_m);
      exp_t        e;
      logic [31:0] acc;
      e.c = '0;
      if (hang_m || l > TIMEOUT) begin
         e.err      = 1;
         e.done_cyc = c0 + TIMEOUT + 1;
         e.busy_len = TIMEOUT + 1;
         e.rises    = 1;
      end else begin
         for (int i = 0; i < LEFT; i++)
            for (int j = 0; j < RIGHT; j++) begin
               acc = '0;
               for (int k = 0; k < MIDDLE; k++) acc = acc + A[i][k] * B[k][j];
               e.c[i][j] = acc;
            end
         e.err      = 0;
         e.done_cyc = c0 + N * (l + 1) + 1;
         e.busy_len = N * (l + 1) + 1;
         e.rises    = N;
      end
      return e;
   endfunction

   task automatic scramble_inputs();
      for (int i = 0; i < LEFT; i++)
         for (int k = 0; k < MIDDLE; k++) in1[i][k] = $urandom;
      for (int k = 0; k < MIDDLE; k++)
         for (int j = 0; j < RIGHT; j++) in2[k][j] = $urandom;
   endtask

   task automatic rand_ab();
      for (int i = 0; i < LEFT; i++)
         for (int k = 0; k < MIDDLE; k++) A[i][k] = $urandom;
      for (int k = 0; k < MIDDLE; k++)
         for (int j = 0; j < RIGHT; j++) B[k][j] = $urandom;
   endtask

   task automatic drive_ab();
      for (int i = 0; i < LEFT; i++)
         for (int k = 0; k < MIDDLE; k++) in1[i][k] = A[i][k];
      for (int k = 0; k < MIDDLE; k++)
         for (int j = 0; j < RIGHT; j++) in2[k][j] = B[k][j];
   endtask

   task automatic run_op(input int l, input bit hang_m, input bit spam);
      exp_t e;
      int   c0;
      bit   got;
      lat  = l;
      hung = hang_m;
      @(negedge clk);
      drive_ab();
      start = 1'b1;
      c0    = cyc;
      e     = model(c0, l, hang_m);
      sb.push_back(e);
      @(negedge clk);
      if (!spam) start = 1'b0;
      chk_i("err_cleared_on_accept", int'(err), 0);
      chk_i("busy_after_accept", int'(busy), 1);
      got = 1'b0;
      for (int n = 0; n < 2000; n++) begin
         if (done) begin
            got = 1'b1;
            break;
         end
         scramble_inputs();
         @(negedge clk);
      end
      if (!got) chk_i("done_wait_expired", 0, 1);
      @(negedge clk);
      start = 1'b0;
      chk_i("no_accept_in_fin", int'(busy), 0);
      @(negedge clk);
      chk_m("result_hold_idle", result, e.c);
      chk_i("err_hold_idle", int'(err), e.err);
      chk_i("vm_en_idle", int'(vm_bus.vm_en), 0);
   endtask

   // scoreboard monitor
   int busy_cnt, rises, low_run, viol;
   bit prev_en;
   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         busy_cnt = 0; rises = 0; low_run = 0; viol = 0; prev_en = 1'b0;
      end else begin
         if (busy) busy_cnt++;
         if (busy && vm_bus.vm_en && !prev_en) begin
            if (rises > 0 && low_run != 1) viol++;
            rises++;
            low_run = 0;
         end else if (busy && !vm_bus.vm_en) begin
            low_run++;
         end
         prev_en = vm_bus.vm_en;
         if (done) begin
            if (sb.size() == 0) begin
               chk_i("unexpected_done", 1, 0);
            end else begin
               e = sb.pop_front();
               chk_m("result", result, e.c);
               chk_i("err_at_done", int'(err), e.err);
               chk_i("done_cycle", cyc, e.done_cyc);
               chk_i("busy_len", busy_cnt, e.busy_len);
               chk_i("busy_in_fin", int'(busy), 1);
               chk_i("vm_en_runs", rises, e.rises);
               chk_i("vm_en_gap_one_cycle", viol, 0);
            end
            busy_cnt = 0; rises = 0; low_run = 0; viol = 0;
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog_expired actual=t%0t expected=finish", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int c0;
      rst_n = 1'b0;
      start = 1'b0;
      in1   = '0;
      in2   = '0;
      #3;
      chk_i("rst_busy", int'(busy), 0);
      chk_i("rst_done", int'(done), 0);
      chk_i("rst_err", int'(err), 0);
      chk_i("rst_vm_en", int'(vm_bus.vm_en), 0);
      chk_m("rst_result", result, '0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // identity A, B = 1..12, latency 3
      for (int i = 0; i < LEFT; i++)
         for (int k = 0; k < MIDDLE; k++) A[i][k] = (i == k) ? 32'd1 : 32'd0;
      for (int k = 0; k < MIDDLE; k++)
         for (int j = 0; j < RIGHT; j++) B[k][j] = 32'(k * RIGHT + j + 1);
      run_op(3, 1'b0, 1'b0);
      chk_i("identity_c12", int'(result[1][2]), 7);

      for (int n = 0; n < 3; n++) begin rand_ab(); run_op(1, 1'b0, 1'b0); end
      for (int n = 0; n < 3; n++) begin rand_ab(); run_op(5, 1'b0, 1'b0); end
      for (int n = 0; n < 2; n++) begin rand_ab(); run_op(int'($urandom_range(1, 8)), 1'b0, 1'b0); end
      rand_ab(); run_op(TIMEOUT, 1'b0, 1'b0);

      // overflow: 3 * (0xFFFFFFFF * 2) wraps
      for (int i = 0; i < LEFT; i++)
         for (int k = 0; k < MIDDLE; k++) A[i][k] = 32'hFFFF_FFFF;
      for (int k = 0; k < MIDDLE; k++)
         for (int j = 0; j < RIGHT; j++) B[k][j] = 32'd2;
      run_op(2, 1'b0, 1'b0);
      chk_i("overflow_entry", int'(result[1][3]), int'(32'hFFFF_FFFA));

      rand_ab(); run_op(4, 1'b1, 1'b0);
      rand_ab(); run_op(2, 1'b0, 1'b0);
      rand_ab(); run_op(TIMEOUT + 1, 1'b0, 1'b0);
      rand_ab(); run_op(2, 1'b0, 1'b1);

      // reset in the middle of product 4
      rand_ab();
      lat  = 3;
      hung = 1'b0;
      @(negedge clk);
      drive_ab();
      start = 1'b1;
      c0    = cyc;
      @(negedge clk);
      start = 1'b0;
      while (cyc < c0 + 4 * (3 + 1) + 2) @(negedge clk);
      chk_i("busy_before_abort", int'(busy), 1);
      #2 rst_n = 1'b0;
      #1;
      chk_i("abort_busy", int'(busy), 0);
      chk_i("abort_done", int'(done), 0);
      chk_i("abort_err", int'(err), 0);
      chk_i("abort_vm_en", int'(vm_bus.vm_en), 0);
      chk_m("abort_result", result, '0);
      @(negedge clk);
      @(negedge clk);
      #2 rst_n = 1'b1;
      rand_ab(); run_op(4, 1'b0, 1'b0);

      repeat (3) @(negedge clk);
      chk_i("scoreboard_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
      $finish;
   end

endmodule
